// File: rtl/l2_arb_pkg.sv
// Shared encodings for the two-port L2 request arbiter.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/l2_arb_pick.sv
// Two-way winner selection: a lone eligible port wins outright, ties go to the
// round-robin pointer or, with FIXED_PRI set, always to port B.
module l2_arb_pick
    import l2_arb_pkg::*;
#(
    parameter int FIXED_PRI = 0
) (
    input  logic [1:0] eligible,
    input  logic       rr_ptr,
    output logic       grant,
    output logic       grant_valid
);

    always_comb begin
        grant       = PORT_A;
        grant_valid = |eligible;
        case (eligible)
            2'b01:   grant = PORT_A;
            2'b10:   grant = PORT_B;
            2'b11:   grant = (FIXED_PRI != 0) ? PORT_B : rr_ptr;
            default: grant = PORT_A;
        endcase
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Serialises instruction-fetch (A) and data (B) requests onto the single L2
// request bus, one whole transaction at a time.
//
//   state | meaning
//   IDLE  | waiting for an eligible port; winner fields latched on exit
//   ISSUE | l2_start high with latched fields, waiting for first l2_done
//   DRAIN | l2_start low, riding out a stretched l2_done before re-arbitrating
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_we,
    input  logic              a_start,
    output logic [DATA_W-1:0] a_q,
    output logic              a_done,

    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_we,
    input  logic              b_start,
    output logic [DATA_W-1:0] b_q,
    output logic              b_done,

    output logic [ADDR_W-1:0] l2_addr,
    output logic [DATA_W-1:0] l2_data,
    output logic              l2_we,
    output logic              l2_start,
    input  logic [DATA_W-1:0] l2_q,
    input  logic              l2_done
);

    arb_state_e state;
    arb_state_e state_nxt;

    logic       rr_ptr;
    logic       winner;
    logic       served_a;
    logic       served_b;
    logic [1:0] eligible;
    logic       grant;
    logic       grant_valid;
    logic       latch_en;
    logic       complete;

    // A port that was just served stays ineligible until it drops start once.
    assign eligible = {b_start & ~served_b, a_start & ~served_a};

    l2_arb_pick #(
        .FIXED_PRI (FIXED_PRI)
    ) u_pick (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch_en  = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    latch_en  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (l2_done) begin
                    complete  = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!l2_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l2_addr  <= '0;
            l2_data  <= '0;
            l2_we    <= 1'b0;
            l2_start <= 1'b0;
            winner   <= PORT_A;
            rr_ptr   <= PORT_A;
            a_q      <= '0;
            b_q      <= '0;
            a_done   <= 1'b0;
            b_done   <= 1'b0;
        end else begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            if (latch_en) begin
                l2_addr  <= (grant == PORT_B) ? b_addr : a_addr;
                l2_data  <= (grant == PORT_B) ? b_data : a_data;
                l2_we    <= (grant == PORT_B) ? b_we   : a_we;
                l2_start <= 1'b1;
                winner   <= grant;
            end
            if (complete) begin
                l2_start <= 1'b0;
                rr_ptr   <= other_port(winner);
                if (winner == PORT_B) begin
                    b_q    <= l2_q;
                    b_done <= 1'b1;
                end else begin
                    a_q    <= l2_q;
                    a_done <= 1'b1;
                end
            end
        end
    end

    // Set wins over clear so a port that dropped start mid-transaction still
    // shows served for exactly one cycle after its done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            served_a <= 1'b0;
            served_b <= 1'b0;
        end else begin
            if (complete && winner == PORT_A) begin
                served_a <= 1'b1;
            end else if (!a_start) begin
                served_a <= 1'b0;
            end
            if (complete && winner == PORT_B) begin
                served_b <= 1'b1;
            end else if (!b_start) begin
                served_b <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter with a behavioural L2 responder.
module tb_l2_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] a_addr = '0, b_addr = '0, l2_addr;
    logic [31:0] a_data = '0, b_data = '0, a_q, b_q, l2_data, l2_q;
    logic        a_we = 1'b0, b_we = 1'b0, a_start = 1'b0, b_start = 1'b0;
    logic        a_done, b_done, l2_we, l2_start, l2_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    l2_port_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .a_we     (a_we),
        .a_start  (a_start),
        .a_q      (a_q),
        .a_done   (a_done),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .b_we     (b_we),
        .b_start  (b_start),
        .b_q      (b_q),
        .b_done   (b_done),
        .l2_addr  (l2_addr),
        .l2_data  (l2_data),
        .l2_we    (l2_we),
        .l2_start (l2_start),
        .l2_q     (l2_q),
        .l2_done  (l2_done)
    );

    // L2 responder: done 4 cycles after a start rise, held done_len cycles.
    int          done_len = 2;
    logic        m_prev;
    logic [2:0]  m_cnt;
    logic [1:0]  m_hold;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_prev  <= 1'b0;
            m_cnt   <= '0;
            m_hold  <= '0;
            l2_done <= 1'b0;
            l2_q    <= '0;
        end else begin
            m_prev <= l2_start;
            if (l2_start && !m_prev) begin
                m_cnt <= 3'd4;
            end else if (m_cnt != 3'd0) begin
                m_cnt <= m_cnt - 3'd1;
                if (m_cnt == 3'd1) begin
                    l2_done <= 1'b1;
                    l2_q    <= {8'h00, l2_addr} ^ 32'hA5A5_0000;
                    m_hold  <= (done_len > 1) ? 2'd1 : 2'd0;
                end
            end else if (m_hold != 2'd0) begin
                m_hold <= m_hold - 2'd1;
            end else begin
                l2_done <= 1'b0;
            end
        end
    end

    // Bus monitor: done counts, pulse width, l2_start low gap, transaction log.
    int          a_done_cnt = 0, b_done_cnt = 0, txn_cnt = 0;
    int          pulse_err = 0, gap_err = 0, low_run = 0;
    bit          seen_txn = 1'b0;
    logic        prev_start = 1'b0, prev_ad = 1'b0, prev_bd = 1'b0;
    logic [23:0] log_addr [64];
    logic [31:0] log_data [64];
    logic        log_we   [64];

    always @(negedge clk) begin
        if (a_done) a_done_cnt <= a_done_cnt + 1;
        if (b_done) b_done_cnt <= b_done_cnt + 1;
        if ((a_done && prev_ad) || (b_done && prev_bd)) pulse_err <= pulse_err + 1;
        if (l2_start && !prev_start) begin
            if (seen_txn && low_run < 2) gap_err <= gap_err + 1;
            seen_txn <= 1'b1;
            log_addr[6'(txn_cnt)] <= l2_addr;
            log_data[6'(txn_cnt)] <= l2_data;
            log_we[6'(txn_cnt)]   <= l2_we;
            txn_cnt <= txn_cnt + 1;
        end
        low_run    <= l2_start ? 0 : low_run + 1;
        prev_start <= l2_start;
        prev_ad    <= a_done;
        prev_bd    <= b_done;
    end

    task automatic wait_a_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a_done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_b_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (b_done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_l2_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (l2_start) begin ok = 1'b1; break; end
        end
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        a_start = 1'b0; b_start = 1'b0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0; a_we = 1'b0; b_we = 1'b0;
        done_len = 2;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (l2_start !== 1'b0) begin failures++; $display("FAIL reset_l2_start got=%0h exp=0", l2_start); end
        checks++; if (l2_addr !== 24'h0 || l2_data !== 32'h0 || l2_we !== 1'b0) begin failures++; $display("FAIL reset_l2_fields got=%0h/%0h/%0h exp=0/0/0", l2_addr, l2_data, l2_we); end
        checks++; if (a_done !== 1'b0 || b_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h/%0h exp=0/0", a_done, b_done); end
        checks++; if (a_q !== 32'h0 || b_q !== 32'h0) begin failures++; $display("FAIL reset_q got=%0h/%0h exp=0/0", a_q, b_q); end
    endtask

    task automatic test_single_read;
        bit ok;
        int base_t, base_a, base_b;
        do_reset();
        base_t = txn_cnt; base_a = a_done_cnt; base_b = b_done_cnt;
        a_addr = 24'h000010; a_we = 1'b0; a_start = 1'b1;
        @(negedge clk);
        checks++; if (l2_start !== 1'b1) begin failures++; $display("FAIL single_start_latency got=%0h exp=1", l2_start); end
        checks++; if (l2_addr !== 24'h000010 || l2_we !== 1'b0) begin failures++; $display("FAIL single_l2_fields got=%0h/%0h exp=10/0", l2_addr, l2_we); end
        wait_a_done(20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_a_done_timeout got=0 exp=1"); end
        checks++; if (a_q !== 32'hA5A5_0010) begin failures++; $display("FAIL single_a_q got=%0h exp=a5a50010", a_q); end
        a_start = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        checks++; if (a_done_cnt - base_a != 1) begin failures++; $display("FAIL single_a_done_count got=%0d exp=1", a_done_cnt - base_a); end
        checks++; if (b_done_cnt - base_b != 0) begin failures++; $display("FAIL single_b_done_count got=%0d exp=0", b_done_cnt - base_b); end
        checks++; if (txn_cnt - base_t != 1) begin failures++; $display("FAIL single_txn_count got=%0d exp=1", txn_cnt - base_t); end
        checks++; if (a_q !== 32'hA5A5_0010) begin failures++; $display("FAIL single_a_q_held got=%0h exp=a5a50010", a_q); end
    endtask

    task automatic test_round_robin;
        int base_t, base_g;
        logic [23:0] exp_addr;
        do_reset();
        base_t = txn_cnt; base_g = gap_err;
        fork
            begin
                bit ok_a;
                for (int r = 0; r < 4; r++) begin
                    a_addr = 24'h001000 + 24'(r); a_we = 1'b0; a_start = 1'b1;
                    wait_a_done(60, ok_a);
                    checks++; if (!ok_a) begin failures++; $display("FAIL rr_a_done_timeout round=%0d got=0 exp=1", r); end
                    checks++; if (a_q !== ((32'h0000_1000 + 32'(r)) ^ 32'hA5A5_0000)) begin failures++; $display("FAIL rr_a_q round=%0d got=%0h exp=%0h", r, a_q, (32'h0000_1000 + 32'(r)) ^ 32'hA5A5_0000); end
                    a_start = 1'b0;
                    @(negedge clk);
                end
            end
            begin
                bit ok_b;
                for (int r = 0; r < 4; r++) begin
                    b_addr = 24'h002000 + 24'(r); b_we = 1'b0; b_start = 1'b1;
                    wait_b_done(60, ok_b);
                    checks++; if (!ok_b) begin failures++; $display("FAIL rr_b_done_timeout round=%0d got=0 exp=1", r); end
                    checks++; if (b_q !== ((32'h0000_2000 + 32'(r)) ^ 32'hA5A5_0000)) begin failures++; $display("FAIL rr_b_q round=%0d got=%0h exp=%0h", r, b_q, (32'h0000_2000 + 32'(r)) ^ 32'hA5A5_0000); end
                    b_start = 1'b0;
                    @(negedge clk);
                end
            end
        join
        repeat (4) @(negedge clk);
        #1;
        checks++; if (txn_cnt - base_t != 8) begin failures++; $display("FAIL rr_txn_count got=%0d exp=8", txn_cnt - base_t); end
        for (int i = 0; i < 8; i++) begin
            exp_addr = ((i % 2) == 0) ? 24'h001000 + 24'(i / 2) : 24'h002000 + 24'(i / 2);
            checks++; if (log_addr[6'(base_t + i)] !== exp_addr) begin failures++; $display("FAIL rr_grant_order idx=%0d got=%0h exp=%0h", i, log_addr[6'(base_t + i)], exp_addr); end
        end
        checks++; if (gap_err != base_g) begin failures++; $display("FAIL rr_start_gap got=%0d exp=%0d", gap_err, base_g); end
        checks++; if (pulse_err != 0) begin failures++; $display("FAIL rr_done_pulse_width got=%0d exp=0", pulse_err); end
    endtask

    task automatic test_hold_no_reserve;
        bit ok;
        int base_t, base_a;
        do_reset();
        base_t = txn_cnt; base_a = a_done_cnt;
        a_addr = 24'h000030; a_we = 1'b0; a_start = 1'b1;
        wait_a_done(20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL hold_first_timeout got=0 exp=1"); end
        repeat (10) @(negedge clk);
        #1;
        checks++; if (txn_cnt - base_t != 1) begin failures++; $display("FAIL hold_no_reserve_txn got=%0d exp=1", txn_cnt - base_t); end
        checks++; if (a_done_cnt - base_a != 1) begin failures++; $display("FAIL hold_no_reserve_done got=%0d exp=1", a_done_cnt - base_a); end
        a_start = 1'b0;
        @(negedge clk);
        a_start = 1'b1;
        wait_a_done(20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL hold_reraise_timeout got=0 exp=1"); end
        a_start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (txn_cnt - base_t != 2) begin failures++; $display("FAIL hold_reraise_txn got=%0d exp=2", txn_cnt - base_t); end
    endtask

    task automatic test_write_then_read;
        bit ok;
        int base_t;
        do_reset();
        base_t = txn_cnt;
        b_addr = 24'h000100; b_data = 32'hDEAD_BEEF; b_we = 1'b1; b_start = 1'b1;
        wait_l2_start(10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wr_grant_timeout got=0 exp=1"); end
        b_addr = 24'h000003; b_data = 32'h0; b_we = 1'b0;
        wait_b_done(20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wr_b_done_timeout got=0 exp=1"); end
        checks++; if (l2_data !== 32'hDEAD_BEEF || l2_addr !== 24'h000100 || l2_we !== 1'b1) begin failures++; $display("FAIL wr_latched_fields got=%0h/%0h/%0h exp=deadbeef/100/1", l2_data, l2_addr, l2_we); end
        b_start = 1'b0;
        a_addr = 24'h000100; a_data = 32'h1234_5678; a_we = 1'b0; a_start = 1'b1;
        wait_a_done(20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rd_a_done_timeout got=0 exp=1"); end
        checks++; if (a_q !== 32'hA5A5_0100) begin failures++; $display("FAIL rd_a_q got=%0h exp=a5a50100", a_q); end
        a_start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (txn_cnt - base_t != 2) begin failures++; $display("FAIL wr_rd_txn_count got=%0d exp=2", txn_cnt - base_t); end
        checks++; if (log_we[6'(base_t)] !== 1'b1 || log_data[6'(base_t)] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_bus got=%0h/%0h exp=1/deadbeef", log_we[6'(base_t)], log_data[6'(base_t)]); end
        checks++; if (log_we[6'(base_t + 1)] !== 1'b0 || log_addr[6'(base_t + 1)] !== 24'h000100) begin failures++; $display("FAIL rd_bus got=%0h/%0h exp=0/100", log_we[6'(base_t + 1)], log_addr[6'(base_t + 1)]); end
    endtask

    task automatic test_passthrough_single_done;
        bit ok;
        int base_a, base_b;
        do_reset();
        done_len = 1;
        base_a = a_done_cnt; base_b = b_done_cnt;
        b_addr = 24'h800004; b_we = 1'b0; b_start = 1'b1;
        wait_b_done(20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL pt_b_done_timeout got=0 exp=1"); end
        checks++; if (b_q !== 32'hA525_0004) begin failures++; $display("FAIL pt_b_q got=%0h exp=a5250004", b_q); end
        b_start = 1'b0;
        @(negedge clk);
        checks++; if (dut.state !== 2'd0) begin failures++; $display("FAIL pt_back_to_idle got=%0h exp=0", dut.state); end
        repeat (4) @(negedge clk);
        #1;
        checks++; if (b_done_cnt - base_b != 1) begin failures++; $display("FAIL pt_b_done_count got=%0d exp=1", b_done_cnt - base_b); end
        checks++; if (a_done_cnt - base_a != 0 || l2_start !== 1'b0) begin failures++; $display("FAIL pt_quiet got=%0d/%0h exp=0/0", a_done_cnt - base_a, l2_start); end
        done_len = 2;
    endtask

    task automatic test_reset_mid_issue;
        bit ok;
        int base_a, base_b;
        do_reset();
        base_a = a_done_cnt; base_b = b_done_cnt;
        a_addr = 24'h000040; a_data = 32'h5555_AAAA; a_we = 1'b1; a_start = 1'b1;
        wait_l2_start(10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_grant_timeout got=0 exp=1"); end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (l2_start !== 1'b0 || l2_we !== 1'b0) begin failures++; $display("FAIL rst_async_ctrl got=%0h/%0h exp=0/0", l2_start, l2_we); end
        checks++; if (l2_addr !== 24'h0 || l2_data !== 32'h0 || a_q !== 32'h0 || a_done !== 1'b0) begin failures++; $display("FAIL rst_async_data got=%0h/%0h/%0h/%0h exp=0/0/0/0", l2_addr, l2_data, a_q, a_done); end
        a_start = 1'b0; a_we = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        checks++; if (a_done_cnt != base_a || b_done_cnt != base_b) begin failures++; $display("FAIL rst_no_done got=%0d/%0d exp=%0d/%0d", a_done_cnt, b_done_cnt, base_a, base_b); end
        a_addr = 24'h000050; a_start = 1'b1;
        wait_a_done(20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_fresh_timeout got=0 exp=1"); end
        checks++; if (a_q !== 32'hA5A5_0050) begin failures++; $display("FAIL rst_fresh_a_q got=%0h exp=a5a50050", a_q); end
        a_start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_hold_no_reserve();
        test_write_then_read();
        test_passthrough_single_done();
        test_reset_mid_issue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
